// File: rtl/traffic_phase_sched_pkg.sv
// traffic_pkg: shared direction codes and scheduler state encoding.
//   DIR_E/W/S/N : 2-bit direction codes, also the pending-bit positions
//   state_t     : scheduler FSM states
package traffic_pkg;
    localparam logic [1:0] DIR_E = 2'd0;
    localparam logic [1:0] DIR_W = 2'd1;
    localparam logic [1:0] DIR_S = 2'd2;
    localparam logic [1:0] DIR_N = 2'd3;
    typedef enum logic [2:0] {IDLE, ARB, GRANT, BUSY, GAP} state_t;
endpackage

// File: rtl/traffic_phase_sched_if.sv
// traffic_phase_sched_if: request inputs and grant handshake of the phase scheduler.
//   i_start, i_car_req, i_ped_req : scheduling enable and per-direction demand
//   i_grant_rdy, i_seq_done        : light sequencer handshake
//   o_grant_*                      : grant valid, direction, walk and rest flags
//   o_all_red, o_*_pend            : clearance indication and latched demand
interface traffic_phase_sched_if;
    logic       i_start;
    logic [3:0] i_car_req;
    logic [3:0] i_ped_req;
    logic       i_grant_rdy;
    logic       i_seq_done;
    logic       o_grant_vld;
    logic [1:0] o_grant_dir;
    logic       o_grant_ped;
    logic       o_grant_rest;
    logic       o_all_red;
    logic [3:0] o_car_pend;
    logic [3:0] o_ped_pend;
    modport master (
        input  i_start, i_car_req, i_ped_req, i_grant_rdy, i_seq_done,
        output o_grant_vld, o_grant_dir, o_grant_ped, o_grant_rest, o_all_red, o_car_pend, o_ped_pend
    );
    modport slave (
        output i_start, i_car_req, i_ped_req, i_grant_rdy, i_seq_done,
        input  o_grant_vld, o_grant_dir, o_grant_ped, o_grant_rest, o_all_red, o_car_pend, o_ped_pend
    );
endinterface

// File: rtl/traffic_phase_sched_rr_pick4.sv
// rr_pick4: combinational 4-way round-robin picker.
//   req : request bits, ptr : last served index
//   any : some request set, idx : first set bit from ptr+1 upward (mod 4)
module rr_pick4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic       any,
    output logic [1:0] idx
);
    assign any = |req;
    // Walk from the farthest candidate to the nearest so the nearest hit wins.
    always_comb begin
        idx = ptr;
        for (int k = 3; k >= 0; k--)
            if (req[ptr + 2'(k + 1)]) idx = ptr + 2'(k + 1);
    end
endmodule

// File: rtl/traffic_phase_sched.sv
// traffic_phase_sched: round-robin intersection phase scheduler with all-red gap and idle rest grant.
//   clk, reset_n : clock and synchronous active-low reset
//   bus (master) : demand inputs, grant handshake to the light sequencer, status outputs
module traffic_phase_sched
    import traffic_pkg::*;
#(
    parameter logic [1:0] DEF_DIR      = DIR_E,
    parameter int         ALLRED_CYC   = 3,
    parameter int         IDLE_TIMEOUT = 16,
    parameter int         CNT_W        = 5
) (
    input  logic                 clk,
    input  logic                 reset_n,
    traffic_phase_sched_if.master bus
);
    state_t           state, next;
    logic [3:0]       car_pend, ped_pend, clr;
    logic [1:0]       ptr, idx, dir;
    logic             any, ped, rest, accept, take;
    logic [CNT_W-1:0] idle_cnt, gap_cnt;

    rr_pick4 u_pick (.req(car_pend | ped_pend), .ptr(ptr), .any(any), .idx(idx));

    assign accept = state == GRANT && bus.i_grant_rdy;
    assign take   = state == ARB && next == GRANT;
    assign clr    = accept ? 4'b1 << dir : 4'b0;

    always_comb begin
        next = state;
        case (state)
            IDLE:    next = bus.i_start ? ARB : IDLE;
            ARB:     next = !bus.i_start ? IDLE : (any || idle_cnt == CNT_W'(IDLE_TIMEOUT)) ? GRANT : ARB;
            GRANT:   next = bus.i_grant_rdy ? BUSY : GRANT;
            BUSY:    next = !bus.i_seq_done ? BUSY : ALLRED_CYC > 0 ? GAP : bus.i_start ? ARB : IDLE;
            GAP:     next = gap_cnt != CNT_W'(ALLRED_CYC - 1) ? GAP : bus.i_start ? ARB : IDLE;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            car_pend <= '0;
            ped_pend <= '0;
            ptr      <= DIR_N;
            dir      <= DIR_E;
            ped      <= 1'b0;
            rest     <= 1'b0;
            idle_cnt <= '0;
            gap_cnt  <= '0;
        end else begin
            state    <= next;
            // A request arriving on the accept edge re-sets the bit being cleared.
            car_pend <= (car_pend & ~clr) | bus.i_car_req;
            ped_pend <= (ped_pend & ~clr) | bus.i_ped_req;
            idle_cnt <= (state == ARB && next == ARB) ? idle_cnt + 1'b1 : '0;
            gap_cnt  <= state == GAP ? gap_cnt + 1'b1 : '0;
            // Rest grants leave the rotation untouched.
            if (accept && !rest) ptr <= dir;
            if (take) begin
                dir  <= any ? idx : DEF_DIR;
                ped  <= any && ped_pend[idx];
                rest <= !any;
            end
        end
    end

    assign bus.o_grant_vld  = state == GRANT;
    assign bus.o_grant_dir  = dir;
    assign bus.o_grant_ped  = ped;
    assign bus.o_grant_rest = rest;
    assign bus.o_all_red    = state == IDLE || state == GAP;
    assign bus.o_car_pend   = car_pend;
    assign bus.o_ped_pend   = ped_pend;
endmodule
